// File: rtl/ram_loader.sv
// Burst initiator for the single-port data RAM: LOAD writes a valid/ready byte
// stream into consecutive addresses, DUMP streams consecutive words back out.
module ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_load,
    input  logic                  start_dump,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d_in,
    input  logic [DATA_WIDTH-1:0] ram_d_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cur_addr_reg, cur_addr_next;
    logic [ADDR_WIDTH:0]     remaining_reg, remaining_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                    out_valid_reg, out_valid_next;
    logic                    done_reg, done_next;
    logic                    last_word;
    logic                    out_free;

    assign last_word = (remaining_reg == (ADDR_WIDTH+1)'(1));
    // The output register can take a new word when empty or being consumed now.
    assign out_free  = !out_valid_reg || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            remaining_reg <= remaining_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        remaining_next = remaining_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        done_next      = 1'b0;
        in_ready       = 1'b0;
        ram_we         = 1'b0;
        ram_d_in       = '0;

        unique case (state_reg)
            IDLE: begin
                if (start_load || start_dump) begin
                    cur_addr_next  = base_addr;
                    remaining_next = len;
                    // A zero-length burst completes immediately without touching RAM.
                    if (len == '0) begin
                        done_next = 1'b1;
                    end else if (start_load) begin
                        state_next = LOAD;
                    end else begin
                        state_next = DUMP;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                ram_d_in = in_data;
                if (in_valid) begin
                    ram_we         = 1'b1;
                    cur_addr_next  = cur_addr_reg + ADDR_WIDTH'(1);
                    remaining_next = remaining_reg - (ADDR_WIDTH+1)'(1);
                    if (last_word) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            DUMP: begin
                if (out_free) begin
                    out_data_next  = ram_d_out;
                    out_valid_next = 1'b1;
                    cur_addr_next  = cur_addr_reg + ADDR_WIDTH'(1);
                    remaining_next = remaining_reg - (ADDR_WIDTH+1)'(1);
                    if (last_word) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                    done_next      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign ram_addr  = cur_addr_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a behavioural RAM plus queued scoreboards
// for expected writes (LOAD) and expected stream words (DUMP).
module tb_ram_loader;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_load, start_dump;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d_in, ram_d_out;
    logic          busy, done;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic          mem_init_done = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];

    always #5 clk = ~clk;

    ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .start_load(start_load), .start_dump(start_dump),
        .base_addr(base_addr), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
        .busy(busy), .done(done)
    );

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'(i);
        return v ^ 8'h5A;
    endfunction

    // Single-port RAM: asynchronous read, write at the clock edge.
    assign ram_d_out = mem[ram_addr];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_init_done <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_d_in;
        end
    end

    task automatic test_reset();
        rst = 1'b1; start_load = 1'b0; start_dump = 1'b0; base_addr = '0; len = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, in_ready, out_valid, ram_we} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/done/in_ready/out_valid/ram_we=%b expected 00000",
                     {busy, done, in_ready, out_valid, ram_we});
        end
        tests_run++;
        if (out_data !== 8'h00 || ram_addr !== 8'h00 || ram_d_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: out_data=%h ram_addr=%h ram_d_in=%h expected 00 00 00",
                     out_data, ram_addr, ram_d_in);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b done=%b expected 0 0", busy, done);
        end
        $display("[TB] reset checked");
    endtask

    // LOAD burst; optionally with in_valid gaps, with start_dump raised together,
    // and chained so the caller can start a new burst in the done cycle.
    task automatic test_load(input logic [7:0] base, input int n, input logic [7:0] seed,
                             input bit gaps, input bit both, input bit chain);
        logic [7:0]  a, d;
        logic [15:0] exp;
        int beats, cyc, bad;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            d = seed + 8'(i);
            wr_q.push_back({a, d});
            ref_mem[a] = d;
        end
        start_load = 1'b1; start_dump = both; base_addr = base; len = 9'(n);
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_start: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        beats = 0; cyc = 0;
        while (beats < n && cyc < 1000) begin
            in_valid   = !(gaps && (cyc % 2 == 1));
            in_data    = seed + 8'(beats);
            start_dump = (cyc == 1);
            #1;
            if (in_valid) begin
                exp = wr_q.pop_front();
                tests_run++;
                if (ram_we !== 1'b1 || ram_addr !== exp[15:8] || ram_d_in !== exp[7:0]) begin
                    tests_failed++;
                    $display("FAIL load_beat: we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                             ram_we, ram_addr, ram_d_in, exp[15:8], exp[7:0]);
                end
                beats++;
            end else begin
                tests_run++;
                if (ram_we !== 1'b0 || in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL load_gap: we=%b in_ready=%b expected 0 1", ram_we, in_ready);
                end
            end
            @(posedge clk); #1;
            start_dump = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (beats < n) begin
            tests_failed++;
            $display("FAIL load_timeout: beats=%0d expected %0d", beats, n);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || ram_addr !== 8'(base + 8'(n))) begin
            tests_failed++;
            $display("FAIL load_done: done=%b busy=%b in_ready=%b addr=%h expected 1 0 0 %h",
                     done, busy, in_ready, ram_addr, 8'(base + 8'(n)));
        end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            if (mem[a] !== ref_mem[a]) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL load_ram: %0d wrong words, expected 0", bad);
        end
        if (!chain) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_after: done=%b busy=%b out_valid=%b expected 0 0 0",
                         done, busy, out_valid);
            end
        end
        $display("[TB] load base=%h len=%0d gaps=%0d both=%0d", base, n, gaps, both);
    endtask

    // DUMP burst; mode 0 keeps out_ready high, mode 1 drives out_ready 1,0,0,...
    task automatic test_dump(input logic [7:0] base, input int n, input int mode);
        logic [7:0] exp, held_data;
        int  cyc, first;
        bit  held;
        for (int i = 0; i < n; i++) rd_q.push_back(ref_mem[8'(base + 8'(i))]);
        start_dump = 1'b1; base_addr = base; len = 9'(n);
        @(posedge clk); #1;
        start_dump = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL dump_start: busy=%b out_valid=%b in_ready=%b expected 1 0 0",
                     busy, out_valid, in_ready);
        end
        cyc = 0; first = -1; held = 1'b0; held_data = '0;
        while (rd_q.size() > 0 && cyc < 3000) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (held) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    tests_failed++;
                    $display("FAIL dump_hold: valid=%b data=%h expected 1 %h", out_valid, out_data, held_data);
                end
            end
            held = 1'b0;
            if (mode == 0 && first >= 0) begin
                tests_run++;
                if (out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL dump_stream: out_valid=%b at cycle %0d expected 1", out_valid, cyc);
                end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) begin
                    first = cyc;
                    tests_run++;
                    if (cyc != 1) begin
                        tests_failed++;
                        $display("FAIL dump_first: first valid at start+%0d expected start+2", cyc + 1);
                    end
                end
                if (out_ready) begin
                    exp = rd_q.pop_front();
                    tests_run++;
                    if (out_data !== exp) begin
                        tests_failed++;
                        $display("FAIL dump_data: got %h expected %h", out_data, exp);
                    end
                end else begin
                    held = 1'b1;
                    held_data = out_data;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (rd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL dump_timeout: %0d words missing, expected 0", rd_q.size());
            rd_q.delete();
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || ram_addr !== 8'(base + 8'(n))) begin
            tests_failed++;
            $display("FAIL dump_done: done=%b busy=%b out_valid=%b addr=%h expected 1 0 0 %h",
                     done, busy, out_valid, ram_addr, 8'(base + 8'(n)));
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL dump_after: done=%b out_valid=%b expected 0 0", done, out_valid);
        end
        $display("[TB] dump base=%h len=%0d mode=%0d", base, n, mode);
    endtask

    task automatic test_zero_len(input bit load);
        start_load = load; start_dump = !load; base_addr = 8'h33; len = '0;
        in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len: done=%b busy=%b we=%b out_valid=%b in_ready=%b expected 1 0 0 0 0",
                     done, busy, ram_we, out_valid, in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || ram_we !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len_after: done=%b we=%b out_valid=%b expected 0 0 0", done, ram_we, out_valid);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        $display("[TB] zero-length %s", load ? "load" : "dump");
    endtask

    task automatic test_back_to_back();
        test_load(8'h20, 5, 8'h30, 1'b1, 1'b0, 1'b1);
        test_dump(8'h20, 5, 1);
    endtask

    task automatic test_reset_mid();
        start_load = 1'b1; base_addr = 8'h80; len = 9'd4;
        @(posedge clk); #1;
        start_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
            ref_mem[8'h80 + 8'(i)] = 8'hC0 + 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: in_ready=%b busy=%b done=%b expected 0 0 0", in_ready, busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: done=%b busy=%b expected 0 0", done, busy);
        end
        tests_run++;
        if (mem[8'h80] !== 8'hC0 || mem[8'h81] !== 8'hC1 || mem[8'h82] !== ref_mem[8'h82]) begin
            tests_failed++;
            $display("FAIL reset_mid_ram: %h %h %h expected c0 c1 %h",
                     mem[8'h80], mem[8'h81], mem[8'h82], ref_mem[8'h82]);
        end
        $display("[TB] reset mid-load");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        test_reset();
        test_load(8'h10, 4, 8'hA1, 1'b0, 1'b0, 1'b0);
        test_dump(8'h10, 4, 0);
        test_dump(8'h10, 4, 1);
        test_load(8'hFE, 4, 8'h01, 1'b0, 1'b0, 1'b0);
        test_dump(8'h00, 256, 0);
        test_zero_len(1'b1);
        test_zero_len(1'b0);
        test_load(8'h40, 2, 8'h77, 1'b0, 1'b1, 1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
